gate_seq_ctrl: RTL and testbench



---
 rtl/gate_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_gate_seq_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/gate_seq_ctrl.sv
// -----------------------------------------------------------------------------
// gate_seq_ctrl
//   Test sequencer for a quad 2-input gate DIP (74x00/08/32/86 family) sitting
//   in a 12-pin GPIO socket. All four gate slots are driven in parallel through
//   the four {A,B} input vectors. After a settle delay the Y outputs are sampled.
//   The chip is then classified as NAND, AND, OR or XOR, or reported as a failure.
//   The FSM advances only on cycles where tick_i=1. Start acceptance in
//   IDLE/DONE is the one exception and happens on any cycle.
//
// Ports
//   clk_i        system clock
//   reset_n_i    synchronous, active-low reset
//   tick_i       step enable for the FSM
//   start_i      begin a test (accepted in IDLE or DONE only)
//   pins_in_i    sampled socket pin levels; slot k uses pins 3k=A, 3k+1=B, 3k+2=Y
//   pins_out_o   drive values for the socket pins
//   pins_dir_o   1 = drive pins_out_o, 0 = high-Z (Y pins are never driven)
//   busy_o       test in progress
//   done_o       result valid; held until the next start or reset
//   gate_type_o  0 NONE, 1 NAND, 2 AND, 3 OR, 4 XOR, 7 FAIL
//   slot_ok_o    bit k set when slot k matched the reported type
// -----------------------------------------------------------------------------
module gate_seq_ctrl #(
  parameter int unsigned SETTLE_TICKS = 2,  // 1..15
  parameter int unsigned MIN_GOOD     = 3   // 1..4
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        tick_i,
  input  logic        start_i,
  input  logic [11:0] pins_in_i,
  output logic [11:0] pins_out_o,
  output logic [11:0] pins_dir_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  gate_type_o,
  output logic [3:0]  slot_ok_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DECIDE = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  // A and B pins of every slot are outputs while a vector is applied.
  localparam logic [11:0] AB_DIR_MASK = 12'b011_011_011_011;
  localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_TICKS - 1);
  localparam logic [2:0]  MIN_GOOD_C  = 3'(MIN_GOOD);

  // Expected responses, bit v = f(A,B) with v = {A,B}. Index 0..3 = NAND, AND, OR, XOR.
  localparam logic [3:0][3:0] PATTERNS = {4'b0110, 4'b1110, 4'b1000, 4'b0111};

  state_e          state_q;
  logic [1:0]      v_q;
  logic [3:0]      settle_q;
  logic [3:0][3:0] resp_q;      // resp_q[k][v] = Y of slot k for vector v

  logic [2:0]      gate_type_d;
  logic [3:0]      slot_ok_d;
  logic            unused_ab_s;

  // Drive pattern for vector v: every slot gets A=v[1], B=v[0]; Y bits stay 0.
  function automatic logic [11:0] drive_vec(input logic [1:0] v);
    logic [11:0] r;
    r = 12'd0;
    for (int k = 0; k < 4; k++) begin
      r[3*k]   = v[1];
      r[3*k+1] = v[0];
    end
    return r;
  endfunction

  // A/B pins are driven by this block, so their read-back levels carry no information.
  assign unused_ab_s = ^{pins_in_i[10:9], pins_in_i[7:6], pins_in_i[4:3], pins_in_i[1:0]};

  // Classification of the collected responses.
  // The first type with the strictly highest match count wins, which gives the
  // NAND > AND > OR > XOR tie priority.
  always_comb begin
    logic [3:0][3:0] match_s;   // match_s[t][k]: slot k equals pattern t
    logic [3:0][2:0] cnt_s;
    logic [1:0]      best_t;
    logic [2:0]      best_cnt;
    match_s  = '0;
    cnt_s    = '0;
    best_t   = 2'd0;
    best_cnt = 3'd0;
    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) begin
        match_s[t][k] = (resp_q[k] == PATTERNS[t]);
        cnt_s[t]      = cnt_s[t] + {2'b00, match_s[t][k]};
      end
    end
    best_cnt = cnt_s[0];
    for (int t = 1; t < 4; t++) begin
      if (cnt_s[t] > best_cnt) begin
        best_cnt = cnt_s[t];
        best_t   = 2'(t);
      end else begin
        best_cnt = best_cnt;
      end
    end
    if (best_cnt >= MIN_GOOD_C) begin
      gate_type_d = {1'b0, best_t} + 3'd1;
      slot_ok_d   = match_s[best_t];
    end else begin
      gate_type_d = 3'd7;
      slot_ok_d   = 4'b0000;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= S_IDLE;
      v_q         <= 2'd0;
      settle_q    <= 4'd0;
      resp_q      <= '0;
      pins_out_o  <= 12'd0;
      pins_dir_o  <= 12'd0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      gate_type_o <= 3'd0;
      slot_ok_o   <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          // Start ignores tick. The previous result stays visible until the next DECIDE.
          if (start_i) begin
            state_q    <= S_DRIVE;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            v_q        <= 2'd0;
            settle_q   <= 4'd0;
            resp_q     <= '0;
            pins_out_o <= drive_vec(2'd0);
            pins_dir_o <= AB_DIR_MASK;
          end
        end
        S_DRIVE: begin
          if (tick_i) begin
            pins_out_o <= drive_vec(v_q);
            pins_dir_o <= AB_DIR_MASK;
            settle_q   <= 4'd0;
            state_q    <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (tick_i) begin
            if (settle_q >= SETTLE_LAST) begin
              settle_q <= 4'd0;
              state_q  <= S_SAMPLE;
            end else begin
              settle_q <= settle_q + 4'd1;
            end
          end
        end
        S_SAMPLE: begin
          if (tick_i) begin
            for (int k = 0; k < 4; k++) begin
              resp_q[k][v_q] <= pins_in_i[3*k+2];
            end
            if (v_q == 2'd3) begin
              state_q <= S_DECIDE;
            end else begin
              // The next vector is applied at once, so the pins are never released between vectors.
              v_q        <= v_q + 2'd1;
              pins_out_o <= drive_vec(v_q + 2'd1);
              state_q    <= S_DRIVE;
            end
          end
        end
        S_DECIDE: begin
          if (tick_i) begin
            gate_type_o <= gate_type_d;
            slot_ok_o   <= slot_ok_d;
            pins_out_o  <= 12'd0;
            pins_dir_o  <= 12'd0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          pins_out_o <= 12'd0;
          pins_dir_o <= 12'd0;
          busy_o     <= 1'b0;
          done_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gate_seq_ctrl
//   Directed bench for gate_seq_ctrl. A behavioural chip model closes the loop
//   from pins_out/pins_dir back to pins_in. Each started test pushes its expected
//   result and completion cycle into a scoreboard queue. An independent monitor
//   pops and compares on every rising edge of done. A second instance with
//   MIN_GOOD=2 shares the stimulus, so the threshold and tie rules can be checked.
// -----------------------------------------------------------------------------
module tb_gate_seq_ctrl;

  typedef struct {
    string      name;
    logic [2:0] gt;
    logic [3:0] ok;
    int         done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic        start;
  logic [11:0] pins_in;
  logic [11:0] pins_out;
  logic [11:0] pins_dir;
  logic        busy;
  logic        done;
  logic [2:0]  gate_type;
  logic [3:0]  slot_ok;

  logic [11:0] unused_pins_out2;
  logic [11:0] unused_pins_dir2;
  logic        unused_busy2;
  logic        done2;
  logic [2:0]  gate_type2;
  logic [3:0]  slot_ok2;

  // Slot model codes: 0 floating(1), 1 NAND, 2 AND, 3 OR, 4 XOR, 5 Y stuck-at-0
  logic [3:0][2:0] slot_cfg;
  logic            slow_mode;
  int              cyc = 0;
  int              checks_total = 0;
  int              checks_passed = 0;
  exp_t            sb_q[$];
  logic            done_prev = 1'b0;

  gate_seq_ctrl #(.SETTLE_TICKS(2), .MIN_GOOD(3)) u_dut (
    .clk_i(clk), .reset_n_i(reset_n), .tick_i(tick), .start_i(start),
    .pins_in_i(pins_in), .pins_out_o(pins_out), .pins_dir_o(pins_dir),
    .busy_o(busy), .done_o(done), .gate_type_o(gate_type), .slot_ok_o(slot_ok)
  );

  gate_seq_ctrl #(.SETTLE_TICKS(2), .MIN_GOOD(2)) u_dut2 (
    .clk_i(clk), .reset_n_i(reset_n), .tick_i(tick), .start_i(start),
    .pins_in_i(pins_in), .pins_out_o(unused_pins_out2), .pins_dir_o(unused_pins_dir2),
    .busy_o(unused_busy2), .done_o(done2), .gate_type_o(gate_type2), .slot_ok_o(slot_ok2)
  );

  function automatic logic [11:0] chip_model(input logic [11:0] po, input logic [11:0] pd,
                                             input logic [3:0][2:0] cfg);
    logic [11:0] r;
    logic a, b, y;
    r = 12'hFFF;
    for (int k = 0; k < 4; k++) begin
      a = pd[3*k]   ? po[3*k]   : 1'b1;
      b = pd[3*k+1] ? po[3*k+1] : 1'b1;
      case (cfg[k])
        3'd1:    y = ~(a & b);
        3'd2:    y = a & b;
        3'd3:    y = a | b;
        3'd4:    y = a ^ b;
        3'd5:    y = 1'b0;
        default: y = 1'b1;
      endcase
      r[3*k]   = a;
      r[3*k+1] = b;
      r[3*k+2] = y;
    end
    return r;
  endfunction

  assign pins_in = chip_model(pins_out, pins_dir, slot_cfg);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick stream: every cycle, or only on edges whose number is a multiple of 4.
  always @(negedge clk) tick = slow_mode ? (((cyc + 1) % 4) == 0) : 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every rising edge of done is one completed test.
  always @(negedge clk) begin
    exp_t e;
    if (done && !done_prev) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_gate_type"}, 32'(gate_type), 32'(e.gt));
        check({e.name, "_slot_ok"},   32'(slot_ok),   32'(e.ok));
        check({e.name, "_done_cyc"},  32'(cyc),       32'(e.done_cyc));
        check({e.name, "_busy_off"},  32'(busy),      32'(0));
        check({e.name, "_dir_rel"},   32'(pins_dir),  32'(0));
        check({e.name, "_out_rel"},   32'(pins_out),  32'(0));
      end
    end
    done_prev <= done;
  end

  task automatic run_test(input string name, input logic [3:0][2:0] cfg,
                          input logic [2:0] gt, input logic [3:0] ok,
                          input logic [2:0] gt2, input logic [3:0] ok2,
                          input bit slow, input bit probe, input bit restart);
    int  e;
    bit  seen;
    slot_cfg  = cfg;
    slow_mode = slow;
    @(negedge clk);
    if (slow) while (((cyc + 1) % 4) != 0) @(negedge clk);
    start = 1'b1;
    e = cyc + 1;
    sb_q.push_back('{name, gt, ok, e + (slow ? 68 : 17)});
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy_n1"}, 32'(busy), 32'(1));
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (probe && cyc == e + 9) begin
        check({name, "_settle_v2_out"}, 32'(pins_out), 32'(12'b001_001_001_001));
        check({name, "_settle_v2_dir"}, 32'(pins_dir), 32'(12'b011_011_011_011));
      end
      if (restart && cyc == e + 10) start = 1'b1;
      if (restart && cyc == e + 14) start = 1'b0;
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) check({name, "_done_timeout"}, 32'(0), 32'(1));
    check({name, "_mg2_gate_type"}, 32'(gate_type2), 32'(gt2));
    check({name, "_mg2_slot_ok"},   32'(slot_ok2),   32'(ok2));
    check({name, "_mg2_done"},      32'(done2),      32'(1));
    repeat (3) @(negedge clk);
    check({name, "_done_held"}, 32'(done), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    reset_n   = 1'b0;
    start     = 1'b0;
    tick      = 1'b1;
    slow_mode = 1'b0;
    slot_cfg  = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    check("rst_pins_dir",  32'(pins_dir),  32'(0));
    check("rst_pins_out",  32'(pins_out),  32'(0));
    check("rst_busy",      32'(busy),      32'(0));
    check("rst_done",      32'(done),      32'(0));
    check("rst_gate_type", 32'(gate_type), 32'(0));
    check("rst_slot_ok",   32'(slot_ok),   32'(0));
    repeat (5) @(negedge clk);

    // cfg is packed with slot 3 first: {slot3, slot2, slot1, slot0}
    run_test("and4",    {3'd2, 3'd2, 3'd2, 3'd2}, 3'd2, 4'b1111, 3'd2, 4'b1111, 1'b0, 1'b0, 1'b0);
    run_test("xor_s2",  {3'd4, 3'd5, 3'd4, 3'd4}, 3'd4, 4'b1011, 3'd4, 4'b1011, 1'b0, 1'b0, 1'b0);
    run_test("mixed",   {3'd3, 3'd3, 3'd1, 3'd1}, 3'd7, 4'b0000, 3'd1, 4'b0011, 1'b0, 1'b0, 1'b0);
    run_test("float",   {3'd0, 3'd0, 3'd0, 3'd0}, 3'd7, 4'b0000, 3'd7, 4'b0000, 1'b0, 1'b1, 1'b0);
    run_test("and_slow",{3'd2, 3'd2, 3'd2, 3'd2}, 3'd2, 4'b1111, 3'd2, 4'b1111, 1'b1, 1'b0, 1'b1);

    // Abort a run with a one-cycle reset during SETTLE of vector 1.
    slow_mode = 1'b0;
    slot_cfg  = {3'd2, 3'd2, 3'd2, 3'd2};
    @(negedge clk);
    start = 1'b1;
    e = cyc + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < e + 5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_pins_dir",  32'(pins_dir),  32'(0));
    check("abort_busy",      32'(busy),      32'(0));
    check("abort_done",      32'(done),      32'(0));
    check("abort_gate_type", 32'(gate_type), 32'(0));
    repeat (2) @(negedge clk);
    run_test("post_rst", {3'd4, 3'd4, 3'd4, 3'd4}, 3'd4, 4'b1111, 3'd4, 4'b1111, 1'b0, 1'b0, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'(0));
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
